// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, one stop bit, oversampled by CLKS_PER_BIT.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN, which adds
// a PARITY state and a sticky parity_err output (8E1 framing instead of 8N1).
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    localparam logic [15:0] HalfM1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FullM1 = 16'(CLKS_PER_BIT - 1);

    logic        sync1_q, rx_s;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        good, fe_set, consume;
`ifdef UART_RX_PARITY_EN
    logic        perr_q, perr_d;
    logic        par_bad_q, par_bad_d;
    logic        pe_set;
`endif

    // Two-flop synchronizer; resets high so an idle line does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s    <= sync1_q;
        end
    end

    // Frame FSM: bit timing, data shifting and stop/parity decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        good    = 1'b0;
        fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_set    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfM1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A line already back high at mid-bit was only a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (cnt_q == FullM1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == FullM1) begin
                    cnt_d     = '0;
                    state_d   = StStop;
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_bad_d = ^shift_q ^ rx_s;
                    pe_set    = ^shift_q ^ rx_s;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        good = !par_bad_q;
`else
                        good = 1'b1;
`endif
                    end else begin
                        fe_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output handshake and sticky flags; a new error event beats a simultaneous clear.
    always_comb begin
        consume = valid_q & rx_ready;
        data_d  = data_q;
        valid_d = valid_q & ~consume;
        ovr_d   = ovr_q & ~err_clr;
        ferr_d  = fe_set | (ferr_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
        perr_d  = pe_set | (perr_q & ~err_clr);
`endif
        if (good) begin
            if (!valid_q || consume) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT = 16; honours UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int Cpb = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int tests = 0;
    int fails = 0;

    // Monitor: counts rx_valid rising edges and captures data on each.
    int         vcount = 0;
    logic [7:0] vdata = 8'h00;
    logic       vprev = 1'b0;

    uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clr  (err_clr)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid && !vprev) begin
            vcount = vcount + 1;
            vdata  = rx_data;
        end
        vprev = rx_valid;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_cnt;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (Cpb) @(negedge clk);
    endtask

    // Sends start, 8 data bits LSB first, optional parity bit, then the given stop level.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 20, exp_cnt: 1, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, gap: 20, exp_cnt: 0, exp_fe: 1'b1};
        vecs[2] = '{data: 8'h00, stop: 1'b1, gap: 0,  exp_cnt: 1, exp_fe: 1'b0};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, gap: 0,  exp_cnt: 1, exp_fe: 1'b0};
        vecs[4] = '{data: 8'h5A, stop: 1'b1, gap: 0,  exp_cnt: 1, exp_fe: 1'b0};
        vecs[5] = '{data: 8'hC3, stop: 1'b1, gap: 20, exp_cnt: 1, exp_fe: 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset rx_data", int'(rx_data), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset overrun", int'(overrun), 0);
        rst_n = 1'b1;
        idle(10);

        // Table-driven frames with rx_ready held high.
        for (int v = 0; v < 6; v++) begin
            vcount = 0;
            send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop);
            check($sformatf("v%0d valid pulses", v), vcount, vecs[v].exp_cnt);
            if (vecs[v].exp_cnt == 1) check($sformatf("v%0d rx_data", v), int'(vdata),
                                            int'(vecs[v].data));
            check($sformatf("v%0d frame_err", v), int'(frame_err), int'(vecs[v].exp_fe));
            check($sformatf("v%0d overrun", v), int'(overrun), 0);
            check($sformatf("v%0d rx_valid low", v), int'(rx_valid), 0);
            if (vecs[v].exp_fe) begin
                pulse_clr();
                check($sformatf("v%0d frame_err cleared", v), int'(frame_err), 0);
            end
            idle(vecs[v].gap);
        end

        // Short low glitch is rejected.
        vcount = 0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch valid", vcount, 0);
        check("glitch frame_err", int'(frame_err), 0);
        check("glitch overrun", int'(overrun), 0);

        // Overrun: two back-to-back frames with no consumer.
        rx_ready = 1'b0;
        vcount = 0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle(4);
        check("ovr valid pulses", vcount, 1);
        check("ovr rx_valid held", int'(rx_valid), 1);
        check("ovr rx_data kept", int'(rx_data), 8'h11);
        check("ovr overrun", int'(overrun), 1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr rx_valid dropped", int'(rx_valid), 0);
        pulse_clr();
        check("ovr overrun cleared", int'(overrun), 0);
        idle(10);

        // Reset mid-frame during data bit 4 of 0xFF.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (Cpb / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst rx_data", int'(rx_data), 0);
        check("midrst rx_valid", int'(rx_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        vcount = 0;
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(4);
        check("midrst valid pulses", vcount, 1);
        check("midrst rx_data after", int'(vdata), 8'h5A);
        check("midrst frame_err", int'(frame_err), 0);
        check("midrst overrun", int'(overrun), 0);

`ifdef UART_RX_PARITY_EN
        // Bad even parity on 0x07 (needs parity bit 1).
        idle(10);
        vcount = 0;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(4);
        check("par parity_err", int'(parity_err), 1);
        check("par valid pulses", vcount, 0);
        check("par frame_err", int'(frame_err), 0);
        pulse_clr();
        check("par parity_err cleared", int'(parity_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter CLKS_PER_BIT, default 434, SHALL give clk cycles per UART bit period (50 MHz / 115200); legal range 4..65535.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port rx, input, 1: asynchronous serial line, idle high.
REQ-006 Port rx_data, output, 8: last received byte, LSB first on line.
REQ-007 Port rx_valid, output, 1: rx_data holds an unconsumed byte.
REQ-008 Port rx_ready, input, 1: consumer accepts byte when rx_valid & rx_ready.
REQ-009 Port frame_err, output, 1: sticky; stop bit sampled low.
REQ-010 Port overrun, output, 1: sticky; byte completed while rx_valid was still high.
REQ-011 Port err_clr, input, 1: clears frame_err, overrun (and parity_err) on the next edge.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (present only with UART_RX_PARITY_EN), STOP.
REQ-014 IDLE: on rx_s == 0, go to START and clear the bit-period counter.
REQ-015 START: at count CLKS_PER_BIT/2 - 1 (mid-bit), rx_s == 0 -> DATA with counter cleared; rx_s == 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles into shift register bit[idx], idx 0..7 with 3-bit index; after idx 7 -> PARITY or STOP.
REQ-017 STOP: sample at full bit period; rx_s == 1 -> byte good; rx_s == 0 -> set frame_err and discard byte; either way -> IDLE.
REQ-018 Good byte: rx_data loads shift register, rx_valid = 1 on the cycle after the stop sample.
REQ-019 If rx_valid is already 1 when a good byte completes, rx_data and rx_valid SHALL be kept unchanged, overrun SHALL be set, and the new byte dropped.
REQ-020 rx_valid SHALL clear on the edge where rx_valid & rx_ready; if a new byte completes on the same edge, the new byte loads, rx_valid stays 1, and no overrun is flagged.
REQ-021 rx_data SHALL remain stable while rx_valid == 1.
REQ-022 If err_clr coincides with a new error event, the new event SHALL win (flag set).
REQ-023 Receiver SHALL resynchronize after IDLE without waiting for a full idle character; back-to-back frames with one stop bit are received.
REQ-024 Latency: rx_valid rises at most CLKS_PER_BIT/2 + 3 cycles after the nominal end of the stop bit.

Reset
REQ-025 On rst_n low, asynchronously: state = IDLE, counters = 0, synchronizer flops = 1, rx_data = 0x00, rx_valid = 0, frame_err = 0, overrun = 0, parity_err = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release, the receiver waits for a new falling edge in IDLE.

Configuration
REQ-027 Macro UART_RX_PARITY_EN SHALL, when defined, add state PARITY after DATA and an output parity_err (1 bit, sticky).
REQ-028 With UART_RX_PARITY_EN: PARITY samples one bit of even parity; on mismatch set parity_err and discard byte; STOP is still checked.
REQ-029 Without UART_RX_PARITY_EN: no PARITY state, no parity_err port, and the frame is 8N1.

Verification (CLKS_PER_BIT = 16)
REQ-030 8N1 frame 0xA5, rx_ready = 1 -> rx_data = 0xA5, one-cycle rx_valid, no flags.
REQ-031 rx low pulse of 4 cycles, then high -> stays IDLE, rx_valid = 0, no flags.
REQ-032 Frame 0x3C with stop bit low -> frame_err = 1, rx_valid = 0; err_clr pulse -> frame_err = 0.
REQ-033 rx_ready = 0, frames 0x11 then 0x22 -> rx_data = 0x11, overrun = 1; then rx_ready = 1 -> rx_valid drops.
REQ-034 rst_n pulsed low during DATA bit 4 of 0xFF, then clean frame 0x5A -> only 0x5A delivered, no flags.
REQ-035 With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 (even parity requires 1) -> parity_err = 1, rx_valid = 0.
